cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the simple 4-opcode CPU (LOAD, MOV, ADD, XOR).
- Fetches 16-bit instructions from instruction memory over a req/ack handshake, latches them into an instruction register and steps the FETCH/DECODE/EXEC/WB cycle.
- Drives the opcode to the external decode unit and gates its reg_write_enable into a one-cycle register-file write strobe.
- Sits between instruction memory and the decode/ALU/register-file datapath.

Parameters:
- PC_W, 8, program counter and instruction-address width.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_W, 16, instruction width. Fixed field layout: [15:12] opcode, [11:8] rx, [7:4] ry, [7:0] imm.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; high allows instruction fetch.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_W  fetch address; equals pc while imem_req is high.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in that cycle.
- imem_rdata  input  INSTR_W  fetched instruction.
- opcode  output  4  IR[15:12], to the decode unit.
- rx  output  4  IR[11:8], destination/operand A register index.
- ry  output  4  IR[7:4], operand B register index.
- imm  output  8  IR[7:0], immediate.
- cu_reg_write_enable  input  1  write enable from the decode unit.
- rf_write_strobe  output  1  register-file write pulse.
- pc  output  PC_W  current program counter.
- busy  output  1  high in any state except IDLE or HALTED.
- halted  output  1  high in HALTED.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- Reset (async, any state, including mid-fetch) forces:
  - state=IDLE, pc=RESET_PC, IR=0.
  - imem_req=0, rf_write_strobe=0, busy=0, halted=0.
- IDLE: if run=1, go to FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On the ack edge: IR <= imem_rdata, pc <= pc+1 (mod 2^PC_W, so all-ones wraps to 0), go to DECODE.
  - No timeout. Dropping run during FETCH does not abort the fetch.
- DECODE: one cycle for the decode unit to settle. If opcode==4'hF (HALT), go to HALTED; otherwise go to EXEC.
- EXEC: one cycle for the ALU to settle; go to WB.
- WB:
  - rf_write_strobe = cu_reg_write_enable for exactly this one cycle.
  - Unused opcodes 4..14 produce strobe 0 and act as NOPs.
  - Next state: FETCH if run=1, else IDLE.
- HALTED: absorbing state; only rst leaves it. pc stays at the address after the HALT instruction.
- Outputs and timing:
  - opcode/rx/ry/imm are driven from IR at all times and are stable from DECODE through WB.
  - rf_write_strobe is 0 outside WB.
  - Throughput: 4 cycles per instruction plus memory wait; with ack in the first FETCH cycle, WB comes 3 cycles after ack.
- imem_ack outside FETCH is ignored and has no effect on state or IR.
- Simultaneous ack and rst: rst wins.

Optional Feature:
- Macro: SINGLE_STEP_EN. When defined, the block adds input step (1 bit, pulse).
- With SINGLE_STEP_EN: from WB, and from IDLE with run=1, the block enters a WAIT_STEP state (busy=0). It goes to FETCH only on a cycle where step=1 and run=1. A step pulse in any other state is ignored.
- Without the macro: no step port, no WAIT_STEP state; behaviour is exactly as above.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_LOAD=0, OP_MOV=1, OP_ADD=2, OP_XOR=3, OP_HALT=4'hF.
  - ALU select codes PASS_B=0, ADD=1, XOR=2.
  - Instruction field bit positions.
  - The sequencer state enum.
- No sub-module: the FSM, pc and IR fit in one module. The decode unit is instantiated beside the sequencer, not inside it.

Test Plan:
- Reset, run=1; memory returns 16'h05A7 (LOAD r5, imm 0xA7) with ack in the first FETCH cycle:
  - Expect imem_addr=0 during FETCH.
  - Expect opcode=0, rx=5, imm=8'hA7 from DECODE.
  - Expect a single rf_write_strobe pulse 3 cycles after ack.
  - Expect pc=1.
- Memory delays ack by 5 cycles: imem_req and imem_addr stay stable for 6 cycles, then normal flow. A spurious ack injected during EXEC leaves IR unchanged.
- Instruction 16'h7123 (unused opcode 7): full sequence runs, rf_write_strobe stays 0, pc increments.
- Instruction 16'hF000 fetched at pc=3: halted=1, busy=0, pc=4. No further imem_req despite run=1 until rst.
- pc preset to 8'hFF by executing 255 NOP/MOV instructions: after the next fetch, pc wraps to 8'h00.
- rst asserted while FETCH waits for ack: imem_req drops asynchronously, pc=RESET_PC. After rst is released with run=1, FETCH restarts at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-opcode CPU: opcodes, ALU selects,
// instruction fields, sequencer states. Option: SINGLE_STEP_EN.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    PASS_B = 2'd0,
    ADD    = 2'd1,
    XOR    = 2'd2
  } alu_sel_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 8;
  localparam int RY_MSB  = 7;
  localparam int RY_LSB  = 4;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
`ifdef SINGLE_STEP_EN
    , S_WAIT_STEP
`endif
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch handshake between sequencer
// (master) and instruction memory (slave).
interface cpu_sequencer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/cpu_sequencer.sv
// FETCH/DECODE/EXEC/WB sequencer with pc and IR.
// Option: SINGLE_STEP_EN adds a step input and WAIT_STEP state.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              INSTR_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  cpu_sequencer_if.master imem,
  output logic [3:0]      opcode,
  output logic [3:0]      rx,
  output logic [3:0]      ry,
  output logic [7:0]      imm,
  input  logic            cu_reg_write_enable,
  output logic            rf_write_strobe,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  seq_state_e         state;
  seq_state_e         state_nx;
  logic [INSTR_W-1:0] ir;
  logic               fetch_done;

  assign fetch_done = (state == S_FETCH) && imem.ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (run) begin
`ifdef SINGLE_STEP_EN
          state_nx = S_WAIT_STEP;
`else
          state_nx = S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        if (imem.ack) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_nx = S_HALTED;
        end else begin
          state_nx = S_EXEC;
        end
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
`ifdef SINGLE_STEP_EN
        state_nx = S_WAIT_STEP;
`else
        state_nx = run ? S_FETCH : S_IDLE;
`endif
      end
      S_HALTED: state_nx = S_HALTED;
`ifdef SINGLE_STEP_EN
      S_WAIT_STEP: begin
        if (step && run) state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // IR and pc only move on the accepted fetch; stray acks are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (fetch_done) begin
      pc <= pc + PC_W'(1);
      ir <= imem.rdata;
    end
  end

  always_comb begin
    imem.req        = 1'b0;
    rf_write_strobe = 1'b0;
    busy            = 1'b1;
    halted          = 1'b0;
    unique case (state)
      S_IDLE:   busy = 1'b0;
      S_FETCH:  imem.req = 1'b1;
      S_WB:     rf_write_strobe = cu_reg_write_enable;
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
`ifdef SINGLE_STEP_EN
      S_WAIT_STEP: busy = 1'b0;
`endif
      default: ;
    endcase
  end

  assign imem.addr = pc;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign rx     = ir[RX_MSB:RX_LSB];
  assign ry     = ir[RY_MSB:RY_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: memory-driving stimulus
// pushes expectations, a monitor checks each fetched instruction.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic [3:0] rx;
  logic [3:0] ry;
  logic [7:0] imm;
  logic       cu_we;
  logic       strobe;
  logic [7:0] pc;
  logic       busy;
  logic       halted;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(8), .INSTR_W(16)) imem_bus ();

  // stand-in decode unit: only the four real opcodes write
  assign cu_we = (opcode <= OP_XOR);

  cpu_sequencer #(
    .PC_W(8),
    .RESET_PC(8'h00),
    .INSTR_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .imem(imem_bus),
    .opcode(opcode),
    .rx(rx),
    .ry(ry),
    .imm(imm),
    .cu_reg_write_enable(cu_we),
    .rf_write_strobe(strobe),
    .pc(pc),
    .busy(busy),
    .halted(halted)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic        strobe;
    logic [7:0]  pc;
    logic        halt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic serve(input logic [15:0] instr, input int dly,
                       input logic [7:0] addr, input logic [7:0] npc,
                       input logic estb, input bit spurious);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!imem_bus.req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: no req for addr %0h", addr);
      return;
    end
    e.addr   = addr;
    e.instr  = instr;
    e.strobe = estb;
    e.pc     = npc;
    e.halt   = (instr[15:12] == 4'hF);
    exp_q.push_back(e);
    for (int k = 0; k < dly; k++) begin
      chk("req_hold", imem_bus.req, 1);
      chk("addr_hold", imem_bus.addr, addr);
      @(negedge clk);
    end
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = instr;
    @(negedge clk);
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 16'hDEAD;
    if (spurious) begin
      @(negedge clk);
      imem_bus.ack   = 1'b1;
      imem_bus.rdata = 16'hFFFF;
      @(negedge clk);
      imem_bus.ack   = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && imem_bus.req && imem_bus.ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: addr %0h", imem_bus.addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("fetch_addr", imem_bus.addr, mon_e.addr);
          @(negedge clk);
          #2;
          chk("dec_opcode", opcode, mon_e.instr[15:12]);
          chk("dec_rx", rx, mon_e.instr[11:8]);
          chk("dec_ry", ry, mon_e.instr[7:4]);
          chk("dec_imm", imm, mon_e.instr[7:0]);
          chk("dec_strobe", strobe, 0);
          chk("dec_busy", busy, 1);
          @(negedge clk);
          #2;
          if (mon_e.halt) begin
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_pc", pc, mon_e.pc);
          end else begin
            chk("exec_strobe", strobe, 0);
            @(negedge clk);
            #2;
            chk("wb_strobe", strobe, mon_e.strobe);
            chk("wb_opcode", opcode, mon_e.instr[15:12]);
            chk("wb_rx", rx, mon_e.instr[11:8]);
            chk("wb_imm", imm, mon_e.instr[7:0]);
            chk("wb_pc", pc, mon_e.pc);
            chk("wb_busy", busy, 1);
          end
        end
      end
    end
  end

  initial begin
    logic       seen;
    logic [7:0] a;
    logic [15:0] ins;
    int         n;
    rst            = 1'b1;
    run            = 1'b0;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_bus.req, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_opcode", opcode, 0);
    rst = 1'b0;
    run = 1'b1;

    serve(16'h05A7, 0, 8'h00, 8'h01, 1'b1, 1'b0);
    serve(16'h3412, 5, 8'h01, 8'h02, 1'b1, 1'b1);
    serve(16'h7123, 0, 8'h02, 8'h03, 1'b0, 1'b0);
    serve(16'hF000, 0, 8'h03, 8'h04, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (imem_bus.req) seen = 1'b1;
    end
    chk("halt_no_req", seen, 0);
    chk("halt_stays", halted, 1);
    chk("halt_pc_hold", pc, 8'h04);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 256; i++) begin
      a   = 8'(i);
      ins = (i % 2 == 1) ? 16'h7000 : {8'h12, a};
      serve(ins, 0, a, 8'(i + 1), (i % 2 == 0), 1'b0);
    end
    run = 1'b0;
    repeat (6) @(negedge clk);
    chk("run_low_busy", busy, 0);
    chk("run_low_req", imem_bus.req, 0);
    chk("run_low_pc", pc, 8'h01);

    run = 1'b1;
    n = 0;
    @(negedge clk);
    while (!imem_bus.req && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("pre_rst_req", imem_bus.req, 1);
    chk("pre_rst_addr", imem_bus.addr, 8'h01);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_req", imem_bus.req, 0);
    chk("async_rst_pc", pc, 8'h00);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    serve(16'h2345, 0, 8'h00, 8'h01, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
